olivia_multicycle_ctrl: RTL
===========================

// Module: olivia_multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the Olivia LEGv8 datapath. Steps each instruction through
//  FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the PC, IR, register-file, ALU-mux and
//  memory strobes with ready handshakes to instruction and data memory.
//  It also provides a memory watchdog and a retired-instruction counter.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles a memory request may wait for ready before FAULT (>=1)
//  CNT_W           32   width of retired-instruction counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  opcode      in   11     instruction[31:21] from the IR (valid from DECODE on)
//  zero_flag   in   1      ALU zero flag (sampled in EXECUTE)
//  imem_ready  in   1      instruction memory has data / accepted request this cycle
//  dmem_ready  in   1      data memory completed read/write this cycle
//  imem_req    out  1      instruction fetch request
//  ir_write    out  1      load IR (FETCH && imem_ready)
//  pc_write    out  1      PC update strobe (last cycle of the instruction)
//  pc_src      out  1      0: PC+4, 1: PC + (sign-extended offset << 2)
//  reg2loc     out  1      1: second read register = Rt (instruction[4:0])
//  alu_src     out  1      1: ALU B operand = sign-extended immediate
//  alu_op      out  2      00 add (LDUR/STUR), 01 pass-B/compare (CBZ), 10 R-type funct
//  dmem_read   out  1      data read request
//  dmem_write  out  1      data write request
//  mem2reg     out  1      1: writeback from memory
//  reg_write   out  1      register-file write strobe
//  illegal     out  1      1-cycle pulse: unsupported opcode decoded
//  fault       out  1      sticky: memory watchdog expired
//  retired     out  CNT_W  count of completed instructions
//  state       out  3      current state (debug)
// BEHAVIOUR
//  - Reset (rst=1 at a clock edge): state<=FETCH, class<=NOP, wait_cnt<=0, retired<=0, fault<=0.
//    While rst=1, all strobe outputs are forced to 0. Reset mid-instruction aborts it: no
//    reg/mem/PC write completes.
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 FAULT=7. Outputs are decoded from the
//    registered state and class, plus same-cycle ready where noted.
//  - FETCH:  imem_req=1. If imem_ready=1: ir_write=1, ->DECODE. Otherwise stay in FETCH.
//    Zero-wait operation is allowed: ready may be high in the same cycle as req.
//  - DECODE: latch class from opcode:
//      R-type = 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR
//      LDUR = 11111000010; STUR = 11111000000
//      CBZ = opcode[10:3]==10110100; B = opcode[10:5]==000101
//      Priority order: R, LDUR, STUR, CBZ, B.
//    reg2loc=1 for STUR/CBZ, else 0. ->EXEC.
//    Unknown opcode: illegal=1, pc_write=1, pc_src=0, retired unchanged, ->FETCH.
//  - EXEC:
//      R-type: alu_op=10, alu_src=0, ->WB.
//      LDUR/STUR: alu_op=00, alu_src=1, ->MEM.
//      CBZ: alu_op=01, reg2loc=1, pc_write=1, pc_src=zero_flag, ->FETCH.
//      B: pc_write=1, pc_src=1, ->FETCH.
//  - MEM: alu_src=1, alu_op=00 held. LDUR: dmem_read=1. STUR: dmem_write=1.
//    Request stays asserted until dmem_ready.
//      On ready: LDUR ->WB. STUR: pc_write=1, pc_src=0, ->FETCH.
//  - WB: reg_write=1, mem2reg=(class==LDUR), pc_write=1, pc_src=0, ->FETCH.
//  - Latency with zero waits: R 4, LDUR 5, STUR 4, CBZ/B 3 cycles. Each wait cycle adds 1.
//  - retired increments by 1 in every cycle with pc_write=1 and class!=illegal.
//    It wraps modulo 2^CNT_W.
//  - Watchdog: wait_cnt clears on entering FETCH or MEM and on any ready.
//    It increments each cycle in FETCH/MEM with ready low.
//    When wait_cnt==TIMEOUT_CYCLES-1 and ready is still low: ->FAULT, fault<=1.
//  - FAULT: all strobes 0, remains until rst. Ready inputs are ignored.
//  - Readiness outside FETCH/MEM is ignored. imem_ready and dmem_ready never cross-complete.
// TESTING
//  1. ADD (opcode 10001011000), imem/dmem ready tied 1 -> states 0,1,2,4.
//     reg_write=1 and mem2reg=0 in cycle 4 only; pc_write=1 with pc_src=0; retired 0->1.
//  2. LDUR, dmem_ready low 3 cycles in MEM -> dmem_read high 4 cycles; WB has mem2reg=1, reg_write=1.
//     Total 8 cycles.
//  3. CBZ with zero_flag=1 -> EXEC pc_write=1, pc_src=1. Repeat with zero_flag=0 -> pc_src=0.
//     Both take 3 cycles and no reg_write.
//  4. Opcode 00000000000 -> illegal pulse in DECODE, pc_write=1, retired unchanged, next state FETCH.
//  5. TIMEOUT_CYCLES=4, imem_ready held 0 -> FAULT after 4 FETCH cycles; fault=1 sticky.
//     Only rst clears it; the next cycle after rst is FETCH.
//  6. STUR, rst asserted for 1 cycle while in MEM with dmem_ready=0 -> dmem_write=0 during rst.
//     No pc_write; state=FETCH and retired=0 afterwards.

Source files
------------

// File: rtl/olivia_multicycle_ctrl.sv
// Olivia LEGv8 multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB control,
// memory watchdog and retired-instruction counter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   opcode[10:0]             instruction[31:21] from the IR
//   zero_flag                ALU zero flag, used by CBZ in EXEC
//   imem_ready, dmem_ready   memory ready handshakes
//   imem_req, ir_write       fetch request / IR load
//   pc_write, pc_src         PC update strobe / target select
//   reg2loc, alu_src, alu_op datapath mux and ALU controls
//   dmem_read, dmem_write    data memory requests
//   mem2reg, reg_write       writeback select / register write
//   illegal                  one-cycle pulse on unsupported opcode
//   fault                    sticky watchdog expiry
//   retired[CNT_W-1:0]       completed-instruction count (wraps)
//   state[2:0]               current state, for debug
module olivia_multicycle_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [10:0]      opcode,
   input  logic             zero_flag,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg2loc,
   output logic             alu_src,
   output logic [1:0]       alu_op,
   output logic             dmem_read,
   output logic             dmem_write,
   output logic             mem2reg,
   output logic             reg_write,
   output logic             illegal,
   output logic             fault,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      C_NOP,
      C_R,
      C_LDUR,
      C_STUR,
      C_CBZ,
      C_B,
      C_ILL
   } cls_e;

   localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
   localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
   localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
   localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
   localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
   localparam logic [10:0] OP_STUR = 11'b111_1100_0000;

   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int WC_W =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WC_W-1:0] WC_LAST =
      WC_W'(TIMEOUT_CYCLES - 1);

   state_e             state_q, state_d;
   cls_e               cls_q, cls_d, cls_dec;
   logic [WC_W-1:0]    wait_q, wait_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic               fault_q, fault_d;
   logic               retire;

   always_comb begin
      cls_dec = C_ILL;
      if (opcode == OP_ADD || opcode == OP_SUB ||
          opcode == OP_AND || opcode == OP_ORR) begin
         cls_dec = C_R;
      end else if (opcode == OP_LDUR) begin
         cls_dec = C_LDUR;
      end else if (opcode == OP_STUR) begin
         cls_dec = C_STUR;
      end else if (opcode[10:3] == 8'b1011_0100) begin
         cls_dec = C_CBZ;
      end else if (opcode[10:5] == 6'b00_0101) begin
         cls_dec = C_B;
      end
   end

   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      wait_d     = '0;
      fault_d    = fault_q;
      retire     = 1'b0;
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      mem2reg    = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (wait_q == WC_LAST) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + WC_W'(1);
            end
         end
         S_DECODE: begin
            cls_d   = cls_dec;
            reg2loc = (cls_dec == C_STUR) ||
                      (cls_dec == C_CBZ);
            if (cls_dec == C_ILL) begin
               illegal  = 1'b1;
               pc_write = 1'b1;
               state_d  = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls_q)
               C_R: begin
                  alu_op  = 2'b10;
                  state_d = S_WB;
               end
               C_LDUR, C_STUR: begin
                  alu_src = 1'b1;
                  // STUR keeps Rt selected: it is the store data.
                  reg2loc = (cls_q == C_STUR);
                  state_d = S_MEM;
               end
               C_CBZ: begin
                  alu_op   = 2'b01;
                  reg2loc  = 1'b1;
                  pc_write = 1'b1;
                  pc_src   = zero_flag;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
               C_B: begin
                  pc_write = 1'b1;
                  pc_src   = 1'b1;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            alu_src    = 1'b1;
            reg2loc    = (cls_q == C_STUR);
            dmem_read  = (cls_q == C_LDUR);
            dmem_write = (cls_q == C_STUR);
            if (dmem_ready) begin
               if (cls_q == C_LDUR) begin
                  state_d = S_WB;
               end else begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = S_FETCH;
               end
            end else if (wait_q == WC_LAST) begin
               state_d = S_FAULT;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + WC_W'(1);
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            mem2reg   = (cls_q == C_LDUR);
            pc_write  = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FETCH;
      endcase

      // Reset aborts the instruction: nothing may commit.
      if (rst) begin
         retire     = 1'b0;
         imem_req   = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = 1'b0;
         reg2loc    = 1'b0;
         alu_src    = 1'b0;
         alu_op     = 2'b00;
         dmem_read  = 1'b0;
         dmem_write = 1'b0;
         mem2reg    = 1'b0;
         reg_write  = 1'b0;
         illegal    = 1'b0;
      end

      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         cls_q     <= C_NOP;
         wait_q    <= '0;
         retired_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
         fault_q   <= fault_d;
      end
   end

   assign fault   = fault_q;
   assign retired = retired_q;
   assign state   = state_q;

endmodule
